// File: rtl/adc_lvds_deframe_pkg.sv
// rtl/adc_lvds_deframe_pkg.sv - shared types and constants for the LVDS ADC deframer
package adc_lvds_deframe_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int          DEF_WIDTH = 14;
  localparam logic [13:0] DEF_PAT_A = 14'h1A5C;
  localparam logic [13:0] DEF_PAT_B = 14'h25A3;
  localparam int          ERR_CNT_W = 16;
  localparam int          CNT_W     = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/adc_lvds_deframe_if.sv
// rtl/adc_lvds_deframe_if.sv - capture-side input and sample/status output bundle
interface adc_lvds_deframe_if
  import adc_lvds_deframe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [2*WIDTH-1:0]   in_data;
  logic                 train_en;
  logic                 relock;
  logic [WIDTH-1:0]     adc_a;
  logic [WIDTH-1:0]     adc_b;
  logic                 out_valid;
  logic                 locked;
  logic                 swapped;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_data, train_en, relock,
    input  adc_a, adc_b, out_valid, locked, swapped, err_count
  );

  modport slave (
    input  in_data, train_en, relock,
    output adc_a, adc_b, out_valid, locked, swapped, err_count
  );
endinterface

// File: rtl/adc_pat_match.sv
// rtl/adc_pat_match.sv - DDR word de-interleave and training-pattern match flags
module adc_pat_match
  import adc_lvds_deframe_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] PAT_A = DEF_PAT_A,
  parameter logic [WIDTH-1:0] PAT_B = DEF_PAT_B
) (
  input  logic [2*WIDTH-1:0] in_data_i,
  output logic [WIDTH-1:0]   raw_a_o,
  output logic [WIDTH-1:0]   raw_b_o,
  output logic               direct_match_o,
  output logic               swap_match_o
);

  // Even bits were captured on the rising edge, odd bits on the falling edge.
  always_comb begin
    raw_a_o = '0;
    raw_b_o = '0;
    for (int k = 0; k < WIDTH; k++) begin
      raw_a_o[k] = in_data_i[2*k];
      raw_b_o[k] = in_data_i[2*k+1];
    end
  end

  assign direct_match_o = (raw_a_o == PAT_A) && (raw_b_o == PAT_B);
  assign swap_match_o   = (raw_a_o == PAT_B) && (raw_b_o == PAT_A);

endmodule

// File: rtl/adc_lvds_deframe.sv
// rtl/adc_lvds_deframe.sv - trains on the ADC test pattern, fixes channel swap, emits samples
// Optional ADC_TWOS_COMP_EN: invert sample MSBs (offset binary to two's complement).
module adc_lvds_deframe
  import adc_lvds_deframe_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] PAT_A      = DEF_PAT_A,
  parameter logic [WIDTH-1:0] PAT_B      = DEF_PAT_B,
  parameter int               LOCK_COUNT = 16,
  parameter int               ERR_LIMIT  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  adc_lvds_deframe_if.slave   bus_io
);

  localparam logic [CNT_W:0] LOCK_CNT_L = LOCK_COUNT[CNT_W:0];
  localparam logic [CNT_W:0] ERR_LIM_L  = ERR_LIMIT[CNT_W:0];

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cand_q, cand_d;
  logic                 swapped_q, swapped_d;
  logic [CNT_W-1:0]     consec_q, consec_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [WIDTH-1:0]     adc_a_q, adc_a_d;
  logic [WIDTH-1:0]     adc_b_q, adc_b_d;
  logic                 valid_q, valid_d;
  logic                 locked_q, locked_d;

  logic [WIDTH-1:0]     raw_a, raw_b;
  logic                 direct_match, swap_match;
  logic                 cand_match, lock_match;
  logic [CNT_W:0]       cnt_inc, consec_inc;

  adc_pat_match #(
    .WIDTH (WIDTH),
    .PAT_A (PAT_A),
    .PAT_B (PAT_B)
  ) u_pat_match (
    .in_data_i      (bus_io.in_data),
    .raw_a_o        (raw_a),
    .raw_b_o        (raw_b),
    .direct_match_o (direct_match),
    .swap_match_o   (swap_match)
  );

  assign cand_match = cand_q    ? swap_match : direct_match;
  assign lock_match = swapped_q ? swap_match : direct_match;
  assign cnt_inc    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign consec_inc = {1'b0, consec_q} + {{CNT_W{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_HUNT;
      cnt_q     <= '0;
      cand_q    <= 1'b0;
      swapped_q <= 1'b0;
      consec_q  <= '0;
      err_q     <= '0;
      adc_a_q   <= '0;
      adc_b_q   <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      swapped_q <= swapped_d;
      consec_q  <= consec_d;
      err_q     <= err_d;
      adc_a_q   <= adc_a_d;
      adc_b_q   <= adc_b_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    if (bus_io.relock) begin
      state_d = ST_HUNT;
      cnt_d   = '0;
      cand_d  = 1'b0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (bus_io.train_en && direct_match) begin
            state_d = ST_VERIFY;
            cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            cand_d  = 1'b0;
          end else if (bus_io.train_en && swap_match) begin
            state_d = ST_VERIFY;
            cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            cand_d  = 1'b1;
          end
        end
        ST_VERIFY: begin
          if (bus_io.train_en && cand_match) begin
            if (cnt_inc == LOCK_CNT_L) begin
              state_d = ST_LOCKED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc[CNT_W-1:0];
            end
          end else begin
            state_d = ST_HUNT;
            cnt_d   = '0;
          end
        end
        ST_LOCKED: begin
          if (bus_io.train_en && !lock_match && consec_inc == ERR_LIM_L) begin
            state_d = ST_HUNT;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_HUNT;
          cnt_d   = '0;
          cand_d  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    err_d     = err_q;
    consec_d  = consec_q;
    swapped_d = swapped_q;
    if (bus_io.relock) begin
      err_d     = '0;
      consec_d  = '0;
      swapped_d = 1'b0;
    end else begin
      if (state_q == ST_VERIFY && state_d == ST_LOCKED) begin
        swapped_d = cand_q;
        consec_d  = '0;
      end
      // Pattern health is only judged while the ADC is still sending training words.
      if (state_q == ST_LOCKED && bus_io.train_en) begin
        if (lock_match) begin
          consec_d = '0;
        end else begin
          err_d    = sat_inc(err_q);
          consec_d = (state_d == ST_HUNT) ? '0 : consec_inc[CNT_W-1:0];
        end
      end
    end

    adc_a_d = swapped_q ? raw_b : raw_a;
    adc_b_d = swapped_q ? raw_a : raw_b;
`ifdef ADC_TWOS_COMP_EN
    adc_a_d[WIDTH-1] = ~adc_a_d[WIDTH-1];
    adc_b_d[WIDTH-1] = ~adc_b_d[WIDTH-1];
`else
    adc_a_d = adc_a_d;
    adc_b_d = adc_b_d;
`endif
    valid_d  = (state_q == ST_LOCKED) && !bus_io.train_en && !bus_io.relock;
    locked_d = (state_d == ST_LOCKED);
  end

  assign bus_io.adc_a     = adc_a_q;
  assign bus_io.adc_b     = adc_b_q;
  assign bus_io.out_valid = valid_q;
  assign bus_io.locked    = locked_q;
  assign bus_io.swapped   = swapped_q;
  assign bus_io.err_count = err_q;

endmodule

// File: tb/tb_adc_lvds_deframe.sv
// tb/tb_adc_lvds_deframe.sv - directed bench with a per-cycle reference model for adc_lvds_deframe
module tb_adc_lvds_deframe;

  localparam int          W      = 14;
  localparam int          LOCK_N = 16;
  localparam int          ERR_N  = 4;
  localparam logic [13:0] PA     = 14'h1A5C;
  localparam logic [13:0] PB     = 14'h25A3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  adc_lvds_deframe_if #(.WIDTH(W)) bus ();

  adc_lvds_deframe #(
    .WIDTH      (W),
    .PAT_A      (PA),
    .PAT_B      (PB),
    .LOCK_COUNT (LOCK_N),
    .ERR_LIMIT  (ERR_N)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [2*W-1:0] pack(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] d;
    for (int k = 0; k < W; k++) begin
      d[2*k]   = a[k];
      d[2*k+1] = b[k];
    end
    return d;
  endfunction

  function automatic logic [W-1:0] fix(input logic [W-1:0] v);
`ifdef ADC_TWOS_COMP_EN
    return v ^ (1 << (W-1));
`else
    return v;
`endif
  endfunction

  // Reference model: tracks a run of agreeing training words and a run of bad words.
  bit          model_live = 0;
  bit          m_lk, m_sw, m_cand;
  int          m_run, m_bad, m_err;
  logic [W-1:0] e_a, e_b;
  bit          e_valid;

  always @(posedge clk) begin
    logic [W-1:0] ra, rb;
    bit dm, sm, te, rl, good;
    for (int k = 0; k < W; k++) begin
      ra[k] = bus.in_data[2*k];
      rb[k] = bus.in_data[2*k+1];
    end
    dm = (ra == PA) && (rb == PB);
    sm = (ra == PB) && (rb == PA);
    te = bus.train_en;
    rl = bus.relock;
    if (!rst_n) begin
      m_lk = 0; m_sw = 0; m_cand = 0; m_run = 0; m_bad = 0; m_err = 0;
      e_a = '0; e_b = '0; e_valid = 0;
      model_live = 1;
    end else begin
      e_a     = fix(m_sw ? rb : ra);
      e_b     = fix(m_sw ? ra : rb);
      e_valid = m_lk && !te && !rl;
      if (rl) begin
        m_lk = 0; m_sw = 0; m_cand = 0; m_run = 0; m_bad = 0; m_err = 0;
      end else if (m_lk) begin
        if (te) begin
          good = m_sw ? sm : dm;
          if (good) m_bad = 0;
          else begin
            if (m_err < 65535) m_err++;
            m_bad++;
            if (m_bad == ERR_N) begin m_lk = 0; m_bad = 0; m_run = 0; end
          end
        end
      end else if (m_run == 0) begin
        if (te && dm) begin m_run = 1; m_cand = 0; end
        else if (te && sm) begin m_run = 1; m_cand = 1; end
      end else if (te && (m_cand ? sm : dm)) begin
        m_run++;
        if (m_run == LOCK_N) begin m_lk = 1; m_sw = m_cand; m_run = 0; m_bad = 0; end
      end else begin
        m_run = 0;
      end
    end
    #2;
    if (model_live) begin
      check("mdl_adc_a", 32'(bus.adc_a), 32'(e_a));
      check("mdl_adc_b", 32'(bus.adc_b), 32'(e_b));
      check("mdl_valid", 32'(bus.out_valid), 32'(e_valid));
      check("mdl_locked", 32'(bus.locked), 32'(m_lk));
      check("mdl_swapped", 32'(bus.swapped), 32'(m_sw));
      check("mdl_err", 32'(bus.err_count), 32'(m_err));
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic te, input logic rl);
    bus.in_data  = pack(a, b);
    bus.train_en = te;
    bus.relock   = rl;
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] ea3, eb3;
`ifdef ADC_TWOS_COMP_EN
    ea3 = 14'h2123; eb3 = 14'h1210;
`else
    ea3 = 14'h0123; eb3 = 14'h3210;
`endif
    bus.in_data = '0; bus.train_en = 1'b1; bus.relock = 1'b0;
    @(negedge clk);

    // 1: reset with random data, then no lock on random words
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) drive(14'($urandom), 14'($urandom), 1'b1, 1'b0);
    check("rst_adc_a", 32'(bus.adc_a), 0);
    check("rst_adc_b", 32'(bus.adc_b), 0);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_swapped", 32'(bus.swapped), 0);
    check("rst_err", 32'(bus.err_count), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(14'($urandom), 14'($urandom), 1'b1, 1'b0);
      check("rand_nolock", 32'(bus.locked), 0);
    end

    // 2: direct lock after 16 words
    for (int i = 0; i < 15; i++) drive(PA, PB, 1'b1, 1'b0);
    check("t2_locked_15", 32'(bus.locked), 0);
    drive(PA, PB, 1'b1, 1'b0);
    check("t2_locked_16", 32'(bus.locked), 1);
    check("t2_swapped", 32'(bus.swapped), 0);
    check("t2_valid", 32'(bus.out_valid), 0);

    // 3: swapped lock, then live data with channels corrected
    drive(PA, PB, 1'b1, 1'b1);
    check("t3_relock", 32'(bus.locked), 0);
    for (int i = 0; i < 16; i++) drive(PB, PA, 1'b1, 1'b0);
    check("t3_locked", 32'(bus.locked), 1);
    check("t3_swapped", 32'(bus.swapped), 1);
    drive(14'h3210, 14'h0123, 1'b0, 1'b0);
    check("t3_adc_a", 32'(bus.adc_a), 32'(ea3));
    check("t3_adc_b", 32'(bus.adc_b), 32'(eb3));
    check("t3_valid", 32'(bus.out_valid), 1);

    // 4: a bad word during verify restarts the count
    drive(PA, PB, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) drive(PA, PB, 1'b1, 1'b0);
    drive(14'h0000, 14'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) drive(PA, PB, 1'b1, 1'b0);
    check("t4_locked_26", 32'(bus.locked), 0);
    drive(PA, PB, 1'b1, 1'b0);
    check("t4_locked_27", 32'(bus.locked), 1);

    // 5: error counting and loss of lock on 4 consecutive bad words
    for (int i = 0; i < 3; i++) drive(14'h0000, 14'h0000, 1'b1, 1'b0);
    check("t5_err3", 32'(bus.err_count), 3);
    drive(PA, PB, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(14'h0000, 14'h0000, 1'b1, 1'b0);
    check("t5_locked_3bad", 32'(bus.locked), 1);
    drive(14'h0000, 14'h0000, 1'b1, 1'b0);
    check("t5_locked_4bad", 32'(bus.locked), 0);
    check("t5_err7", 32'(bus.err_count), 7);

    // 6: relock while streaming, then show the FSM restarted from hunt
    for (int i = 0; i < 16; i++) drive(PA, PB, 1'b1, 1'b0);
    check("t6_locked", 32'(bus.locked), 1);
    check("t6_err_kept", 32'(bus.err_count), 7);
    for (int i = 0; i < 3; i++) drive(14'(i * 3 + 1), 14'(i * 5 + 2), 1'b0, 1'b0);
    check("t6_stream_valid", 32'(bus.out_valid), 1);
    check("t6_stream_a", 32'(bus.adc_a), 32'(fix(14'h0007)));
    drive(14'h0055, 14'h00AA, 1'b0, 1'b1);
    check("t6_valid_off", 32'(bus.out_valid), 0);
    check("t6_locked_off", 32'(bus.locked), 0);
    check("t6_err_clr", 32'(bus.err_count), 0);
    for (int i = 0; i < 15; i++) drive(PA, PB, 1'b1, 1'b0);
    check("t6_hunt_15", 32'(bus.locked), 0);
    drive(PA, PB, 1'b1, 1'b0);
    check("t6_hunt_16", 32'(bus.locked), 1);

    // reset mid-stream with train_en low
    drive(14'h1111, 14'h2222, 1'b0, 1'b0);
    check("mid_valid_pre", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    drive(14'h1111, 14'h2222, 1'b0, 1'b0);
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check("mid_rst_locked", 32'(bus.locked), 0);
    check("mid_rst_adc_a", 32'(bus.adc_a), 0);
    rst_n = 1'b1;
    drive(14'h1111, 14'h2222, 1'b0, 1'b0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
